// File: rtl/tx_serial_param.sv
// rtl/tx_serial_param.sv - parametrised serial transmitter with character FIFO
// Frame: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module tx_serial_param #(
  parameter int DATA_BITS  = 7,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 escreve,
  input  logic [DATA_BITS-1:0] dados,
  output logic                 saida_serial,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 vazio,
  output logic                 cheio,
  output logic                 db_overflow,
  output logic [3:0]           db_estado
);

  localparam bit CFG_OK = (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                          (PARITY >= 0) && (PARITY <= 2) &&
                          (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
                          (CLK_DIV >= 2) && (FIFO_DEPTH >= 2) &&
                          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4
  } estado_t;

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("tx_serial_param: illegal parameter combination");
      assign saida_serial = 1'b1;
      assign pronto       = 1'b0;
      assign ocupado      = 1'b0;
      assign vazio        = 1'b1;
      assign cheio        = 1'b0;
      assign db_overflow  = 1'b0;
      assign db_estado    = 4'd0;
    end else begin : g_core
      localparam int PTR_W  = $clog2(FIFO_DEPTH);
      localparam int CNT_W  = PTR_W + 1;
      localparam int TICK_W = $clog2(CLK_DIV);

      logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
      logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
      logic [CNT_W-1:0]     count_q, count_d;
      logic                 vazio_q, cheio_q, ovf_q;
      estado_t              state_q, state_d;
      logic [TICK_W-1:0]    tick_q, tick_d;
      logic [3:0]           bit_q, bit_d;
      logic [DATA_BITS-1:0] shift_q, shift_d;
      logic                 par_q, par_d, line_q, line_d;
      logic                 push, pop, load, tick_end, pronto_c;
      logic [DATA_BITS-1:0] head;

      assign push     = escreve && !cheio_q;
      assign head     = mem_q[rd_ptr_q];
      assign tick_end = (tick_q == TICK_W'(CLK_DIV - 1));

      always_comb begin
        count_d = count_q;
        case ({push, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end

      always_comb begin
        state_d  = state_q;
        tick_d   = tick_end ? '0 : tick_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        load     = 1'b0;
        pop      = 1'b0;
        pronto_c = 1'b0;
        case (state_q)
          OCIOSO: begin
            tick_d = '0;
            load   = !vazio_q;
          end
          INICIO: if (tick_end) begin
            state_d = DADOS;
            bit_d   = 4'd0;
          end
          DADOS: if (tick_end) begin
            if (bit_q == 4'(DATA_BITS - 1)) begin
              state_d = (PARITY != 0) ? PARIDADE : PARADA;
              bit_d   = 4'd0;
            end else begin
              bit_d   = bit_q + 4'd1;
              shift_d = shift_q >> 1;
            end
          end
          PARIDADE: if (tick_end) begin
            state_d = PARADA;
            bit_d   = 4'd0;
          end
          PARADA: if (tick_end) begin
            if (bit_q == 4'(STOP_BITS - 1)) begin
              pronto_c = 1'b1;
              state_d  = OCIOSO;
              load     = !vazio_q;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
          default: state_d = OCIOSO;
        endcase
        // Loading from PARADA chains frames with no idle cycle in between.
        if (load) begin
          pop     = 1'b1;
          state_d = INICIO;
          tick_d  = '0;
          shift_d = head;
          par_d   = (PARITY == 2) ? ~^head : ^head;
        end
      end

      always_comb begin
        line_d = 1'b1;
        case (state_d)
          INICIO:   line_d = 1'b0;
          DADOS:    line_d = shift_d[0];
          PARIDADE: line_d = par_d;
          default:  line_d = 1'b1;
        endcase
      end

      always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= dados;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
          vazio_q  <= 1'b1;
          cheio_q  <= 1'b0;
          ovf_q    <= 1'b0;
          state_q  <= OCIOSO;
          tick_q   <= '0;
          bit_q    <= 4'd0;
          shift_q  <= '0;
          par_q    <= 1'b0;
          line_q   <= 1'b1;
        end else begin
          if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
          count_q <= count_d;
          vazio_q <= (count_d == '0);
          cheio_q <= (count_d == CNT_W'(FIFO_DEPTH));
          if (escreve && cheio_q) ovf_q <= 1'b1;
          state_q <= state_d;
          tick_q  <= tick_d;
          bit_q   <= bit_d;
          shift_q <= shift_d;
          par_q   <= par_d;
          line_q  <= line_d;
        end
      end

      assign saida_serial = line_q;
      assign pronto       = pronto_c;
      assign ocupado      = (state_q != OCIOSO);
      assign vazio        = vazio_q;
      assign cheio        = cheio_q;
      assign db_overflow  = ovf_q;
      assign db_estado    = state_q;
    end
  endgenerate

endmodule

// File: tb/tb_tx_serial_param.sv
// tb/tb_tx_serial_param.sv - directed self-checking bench for tx_serial_param
// Four instances cover the parameter sets; line activity is logged per cycle.
module tb_tx_serial_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       esc [4];
  logic [6:0] da, dd;
  logic [7:0] db;
  logic [4:0] dc;
  logic       sd [4], pr [4], oc [4], va [4], ch [4], ov [4];
  logic [3:0] st [4];

  tx_serial_param #(.CLK_DIV(8)) dut_a (
    .clock(clk), .reset(rst), .escreve(esc[0]), .dados(da),
    .saida_serial(sd[0]), .pronto(pr[0]), .ocupado(oc[0]), .vazio(va[0]),
    .cheio(ch[0]), .db_overflow(ov[0]), .db_estado(st[0]));

  tx_serial_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLK_DIV(4)) dut_b (
    .clock(clk), .reset(rst), .escreve(esc[1]), .dados(db),
    .saida_serial(sd[1]), .pronto(pr[1]), .ocupado(oc[1]), .vazio(va[1]),
    .cheio(ch[1]), .db_overflow(ov[1]), .db_estado(st[1]));

  tx_serial_param #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .CLK_DIV(2)) dut_c (
    .clock(clk), .reset(rst), .escreve(esc[2]), .dados(dc),
    .saida_serial(sd[2]), .pronto(pr[2]), .ocupado(oc[2]), .vazio(va[2]),
    .cheio(ch[2]), .db_overflow(ov[2]), .db_estado(st[2]));

  tx_serial_param #(.CLK_DIV(4)) dut_d (
    .clock(clk), .reset(rst), .escreve(esc[3]), .dados(dd),
    .saida_serial(sd[3]), .pronto(pr[3]), .ocupado(oc[3]), .vazio(va[3]),
    .cheio(ch[3]), .db_overflow(ov[3]), .db_estado(st[3]));

  localparam int HN = 4096;
  int cyc = 0;
  int sel = 0;
  int tests = 0;
  int fails = 0;
  logic       h_line [HN], h_pr [HN], h_oc [HN], h_va [HN];
  logic [3:0] h_st [HN];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HN) begin
      h_line[cyc] = sd[sel];
      h_pr[cyc]   = pr[sel];
      h_oc[cyc]   = oc[sel];
      h_va[cyc]   = va[sel];
      h_st[cyc]   = st[sel];
    end
  end

  // Reference frame for the default-style instances: start, data LSB first, parity, stops.
  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int nb, input int par);
    logic [15:0] f;
    logic x;
    f = '1;
    f[0] = 1'b0;
    x = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f[1+i] = d[i];
      x = x ^ d[i];
    end
    if (par != 0) f[1+nb] = (par == 2) ? ~x : x;
    return f;
  endfunction

  task automatic wait_past(input int t);
    while (cyc <= t) @(negedge clk);
  endtask

  task automatic send(input int idx, input logic [8:0] d, output int s);
    @(negedge clk);
    s = cyc + 2;
    esc[idx] = 1'b1;
    case (idx)
      0:       da = d[6:0];
      1:       db = d[7:0];
      2:       dc = d[4:0];
      default: dd = d[6:0];
    endcase
    @(negedge clk);
    esc[idx] = 1'b0;
  endtask

  task automatic test_reset;
    logic [9:0] obs;
    for (int i = 0; i < 4; i++) begin
      obs = {sd[i], pr[i], oc[i], va[i], ch[i], ov[i], st[i]};
      tests++;
      if (obs !== 10'b1_0_0_1_0_0_0000) begin
        fails++;
        $display("FAIL reset_state inst %0d: got %b expected %b", i, obs, 10'b1001000000);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {sd[3], pr[3], oc[3], va[3], ch[3], ov[3], st[3]};
    tests++;
    if (obs !== 10'b1_0_0_1_0_0_0000) begin
      fails++;
      $display("FAIL post_release_state: got %b expected %b", obs, 10'b1001000000);
    end
  endtask

  task automatic test_frame_default;
    logic [15:0] f;
    logic [9:0]  lat;
    logic [1:0]  ocf;
    int s, bad, bo;
    sel = 0;
    f = 16'b111111_1_0_1000001_0;
    send(0, 9'h41, s);
    wait_past(s + 81);
    lat = {h_st[s-1], h_line[s-1], h_st[s], h_line[s]};
    tests++;
    if (lat !== {4'd0, 1'b1, 4'd1, 1'b0}) begin
      fails++;
      $display("FAIL t1_start_latency: got %b expected %b", lat, {4'd0, 1'b1, 4'd1, 1'b0});
    end
    bad = 0; bo = 0;
    for (int o = 0; o < 80; o++)
      if (h_line[s+o] !== f[o/8] && bad == 0) begin bad = 1; bo = o; end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL t1_line cycle %0d: got %b expected %b", bo, h_line[s+bo], f[bo/8]);
    end
    bad = 0; bo = 0;
    for (int o = 0; o <= 80; o++)
      if (h_pr[s+o] !== (o == 79) && bad == 0) begin bad = 1; bo = o; end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL t1_pronto cycle %0d: got %b expected %b", bo, h_pr[s+bo], bo == 79);
    end
    ocf = {h_oc[s+79], h_oc[s+80]};
    tests++;
    if (ocf !== 2'b10) begin
      fails++;
      $display("FAIL t1_ocupado_fall: got %b expected %b", ocf, 2'b10);
    end
  endtask

  task automatic test_odd_parity_two_stop;
    logic [15:0] f [2];
    logic [8:0]  d [2];
    int s, bad, bo;
    sel = 1;
    f[0] = 16'b1111_1_1_1_11111111_0;
    f[1] = 16'b1111_1_1_0_11111110_0;
    d[0] = 9'h0FF;
    d[1] = 9'h0FE;
    for (int k = 0; k < 2; k++) begin
      send(1, d[k], s);
      wait_past(s + 49);
      bad = 0; bo = 0;
      for (int o = 0; o < 48; o++)
        if (h_line[s+o] !== f[k][o/4] && bad == 0) begin bad = 1; bo = o; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL t2_line char %0d cycle %0d: got %b expected %b", k, bo, h_line[s+bo], f[k][bo/4]);
      end
      bad = 0; bo = 0;
      for (int o = 0; o <= 48; o++)
        if (h_pr[s+o] !== (o == 47) && bad == 0) begin bad = 1; bo = o; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL t2_pronto char %0d cycle %0d: got %b expected %b", k, bo, h_pr[s+bo], bo == 47);
      end
    end
  endtask

  task automatic test_no_parity;
    logic [15:0] f;
    int s, bad, bo, par_seen;
    sel = 2;
    f = 16'b111111111_1_10101_0;
    send(2, 9'h15, s);
    wait_past(s + 15);
    bad = 0; bo = 0;
    for (int o = 0; o < 14; o++)
      if (h_line[s+o] !== f[o/2] && bad == 0) begin bad = 1; bo = o; end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL t6_line cycle %0d: got %b expected %b", bo, h_line[s+bo], f[bo/2]);
    end
    par_seen = 0;
    for (int o = -1; o <= 15; o++)
      if (h_st[s+o] === 4'd3) par_seen++;
    tests++;
    if (par_seen != 0) begin
      fails++;
      $display("FAIL t6_no_paridade: got %0d parity-state cycles expected 0", par_seen);
    end
    bad = 0; bo = 0;
    for (int o = 0; o <= 14; o++)
      if (h_pr[s+o] !== (o == 13) && bad == 0) begin bad = 1; bo = o; end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL t6_pronto cycle %0d: got %b expected %b", bo, h_pr[s+bo], bo == 13);
    end
  endtask

  task automatic test_fifo_overflow;
    logic [15:0] f;
    logic [1:0]  fl;
    int c0, s, bad, bo, idle_bad;
    sel = 3;
    @(negedge clk);
    c0 = cyc;
    s = c0 + 2;
    for (int v = 1; v <= 5; v++) begin
      esc[3] = 1'b1;
      dd = 7'(v);
      @(negedge clk);
      if (v == 4) begin
        tests++;
        if (ch[3] !== 1'b0) begin
          fails++;
          $display("FAIL t3_not_full_after4: got %b expected 0", ch[3]);
        end
      end
    end
    fl = {ch[3], ov[3]};
    tests++;
    if (fl !== 2'b10) begin
      fails++;
      $display("FAIL t3_full_after5: got cheio/ovf %b expected %b", fl, 2'b10);
    end
    dd = 7'd6;
    @(negedge clk);
    esc[3] = 1'b0;
    fl = {ch[3], ov[3]};
    tests++;
    if (fl !== 2'b11) begin
      fails++;
      $display("FAIL t3_overflow: got cheio/ovf %b expected %b", fl, 2'b11);
    end
    wait_past(s + 212);
    for (int n = 0; n < 5; n++) begin
      f = mk_frame(9'(n + 1), 7, 1);
      bad = 0; bo = 0;
      for (int o = 0; o < 40; o++)
        if (h_line[s+40*n+o] !== f[o/4] && bad == 0) begin bad = 1; bo = o; end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL t3_frame%0d cycle %0d: got %b expected %b", n + 1, bo, h_line[s+40*n+bo], f[bo/4]);
      end
    end
    idle_bad = 0;
    for (int o = 200; o <= 212; o++)
      if (h_line[s+o] !== 1'b1 || h_oc[s+o] !== 1'b0) idle_bad++;
    tests++;
    if (idle_bad != 0) begin
      fails++;
      $display("FAIL t3_dropped_sixth: got %0d active cycles expected 0", idle_bad);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] f [3];
    logic [6:0]  d [3];
    logic [1:0]  vz;
    int c0, s, bad, bo;
    sel = 3;
    d[0] = 7'h30; d[1] = 7'h55; d[2] = 7'h0F;
    for (int k = 0; k < 3; k++) f[k] = mk_frame({2'b00, d[k]}, 7, 1);
    @(negedge clk);
    c0 = cyc;
    s = c0 + 2;
    for (int k = 0; k < 3; k++) begin
      esc[3] = 1'b1;
      dd = d[k];
      @(negedge clk);
    end
    esc[3] = 1'b0;
    wait_past(s + 126);
    bad = 0; bo = 0;
    for (int o = 0; o < 120; o++)
      if (h_line[s+o] !== f[o/40][(o%40)/4] && bad == 0) begin bad = 1; bo = o; end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL t4_line cycle %0d: got %b expected %b", bo, h_line[s+bo], f[bo/40][(bo%40)/4]);
    end
    bad = 0; bo = 0;
    for (int o = 0; o <= 125; o++)
      if (h_pr[s+o] !== (o == 39 || o == 79 || o == 119) && bad == 0) begin bad = 1; bo = o; end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL t4_pronto cycle %0d: got %b", bo, h_pr[s+bo]);
    end
    bad = 0; bo = 0;
    for (int o = 0; o <= 120; o++)
      if (h_oc[s+o] !== (o < 120) && bad == 0) begin bad = 1; bo = o; end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL t4_ocupado cycle %0d: got %b expected %b", bo, h_oc[s+bo], bo < 120);
    end
    vz = {h_va[s+79], h_va[s+80]};
    tests++;
    if (vz !== 2'b01) begin
      fails++;
      $display("FAIL t4_vazio: got %b expected %b", vz, 2'b01);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [6:0] obs;
    int c1, idle_bad;
    sel = 3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      esc[3] = 1'b1;
      dd = 7'(k * 17);
      @(negedge clk);
    end
    esc[3] = 1'b0;
    for (int i = 0; i < 100 && st[3] !== 4'd2; i++) @(negedge clk);
    @(negedge clk);
    tests++;
    if (st[3] !== 4'd2 || sd[3] !== 1'b0) begin
      fails++;
      $display("FAIL t5_reach_dados: got estado %0d line %b expected 2 and 0", st[3], sd[3]);
    end
    #2 rst = 1'b1;
    #1;
    obs = {sd[3], st[3], va[3], ov[3]};
    tests++;
    if (obs !== 7'b1_0000_1_0) begin
      fails++;
      $display("FAIL t5_async_reset: got %b expected %b", obs, 7'b1000010);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c1 = cyc;
    wait_past(c1 + 60);
    idle_bad = 0;
    for (int o = 0; o <= 60; o++)
      if (h_line[c1+o] !== 1'b1 || h_st[c1+o] !== 4'd0 || h_va[c1+o] !== 1'b1) idle_bad++;
    tests++;
    if (idle_bad != 0) begin
      fails++;
      $display("FAIL t5_idle_after_reset: got %0d non-idle cycles expected 0", idle_bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) esc[i] = 1'b0;
    da = '0; db = '0; dc = '0; dd = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_frame_default;
    test_odd_parity_two_stop;
    test_no_parity;
    test_fifo_overflow;
    test_back_to_back;
    test_reset_mid_frame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_serial_param.md
Name: tx_serial_param

Overview:
Parametrised asynchronous serial transmitter. It is the configurable successor to the fixed 7-bit-even-parity-1-stop transmitter.
- Data width, parity mode, stop-bit count and baud divisor are set by parameters.
- An internal FIFO lets the upstream logic (Sobel result streamer, debug console) queue several characters without waiting for each frame.
- Sits between the pixel/ASCII producer and the GPIO serial pin.

Parameters:
DATA_BITS, 7, data bits per frame; legal range 5..9.
PARITY, 1, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.
CLK_DIV, 434, clocks per bit (50 MHz / 115200); must be >= 2.
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clock  in  1  system clock (50 MHz).
reset  in  1  asynchronous, active-high reset.
escreve  in  1  write strobe; one character is accepted per cycle while cheio=0.
dados  in  DATA_BITS  character to queue; sampled when escreve=1.
saida_serial  out  1  serial line; idle high.
pronto  out  1  one-cycle pulse when a frame's last stop bit completes.
ocupado  out  1  high while a frame is on the line (any state except OCIOSO).
vazio  out  1  FIFO empty.
cheio  out  1  FIFO full.
db_overflow  out  1  sticky flag: a write was attempted while cheio=1.
db_estado  out  4  FSM state code for the hexa7seg display.

Behaviour:
Reset:
- Asynchronous, effective immediately, including mid-frame.
- Output values: saida_serial=1, pronto=0, ocupado=0, vazio=1, cheio=0, db_overflow=0, db_estado=0.
- FIFO pointers and count cleared; queued data discarded.
- Bit-tick counter cleared.

FIFO:
- Write occurs when escreve=1 and cheio=0.
- escreve=1 while cheio=1 is ignored and sets db_overflow. This holds even if a pop happens in the same cycle.
- A simultaneous write and pop when not full leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- vazio and cheio are registered and derived from the count.

FSM states (db_estado codes): OCIOSO=0, INICIO=1, DADOS=2, PARIDADE=3, PARADA=4.
- OCIOSO: saida_serial=1. If vazio=0 at a rising edge: pop the head into the shift register, clear the tick counter, go to INICIO.
  - Latency: a write accepted at edge k into an empty idle block drives saida_serial low after edge k+1.
- INICIO: saida_serial=0 for exactly CLK_DIV cycles, then go to DADOS.
- DADOS: bits sent LSB first, each held CLK_DIV cycles. A bit counter counts 0..DATA_BITS-1.
  - After the last bit, go to PARIDADE if PARITY!=0, otherwise go to PARADA.
- PARIDADE: one bit, CLK_DIV cycles.
  - Even mode: bit = XOR of the data bits.
  - Odd mode: bit = inverted XOR of the data bits.
  - Parity is computed from the character at load time.
- PARADA: saida_serial=1 for STOP_BITS*CLK_DIV cycles.
  - On the final cycle of the stop period, pronto=1 for that one cycle.
  - If vazio=0 in that same cycle, pop and go directly to INICIO, so back-to-back frames have zero idle gap.
  - Otherwise go to OCIOSO.

Timing and outputs:
- Bit timing: the tick counter runs 0..CLK_DIV-1. The bit advances on the count of CLK_DIV-1. The counter is zeroed on every frame load.
- Frame length = CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles exactly.
- saida_serial is driven from a register, so the line is glitch-free.
- ocupado=1 in every state except OCIOSO.
- Out-of-range parameters are a configuration error; the block generates no hardware for them. A simulation $error is issued at elaboration.

Test Plan:
1. Defaults with CLK_DIV=8. Write dados=7'h41 once.
   -> Line carries 0, 1,0,0,0,0,0,1, parity 0, stop 1; each bit is 8 cycles; frame is 80 cycles.
   -> pronto pulses exactly at cycle 80 after the start edge; ocupado falls the next cycle.
2. DATA_BITS=8, PARITY=2, STOP_BITS=2, CLK_DIV=4. Write 8'hFF.
   -> Bits: 0, eight 1s, parity 1, two stop 1s; total 48 cycles.
   -> Repeat with 8'hFE: parity 0.
3. FIFO_DEPTH=4, idle block. escreve=1 for 5 consecutive cycles with data 1..5.
   -> All 5 accepted (data 1 popped on the second edge); cheio=1 after the fifth.
   -> Sixth write (data 6) is dropped and db_overflow=1.
   -> Characters 1..5 are transmitted in order.
4. Back-to-back: queue 3 characters, CLK_DIV=4, defaults.
   -> Each start bit begins the cycle after the previous final stop cycle, with no idle gap.
   -> Three pronto pulses spaced exactly 40 cycles apart; vazio=1 after the third pop.
5. Reset mid-frame: assert reset during DADOS with 2 characters queued.
   -> saida_serial=1, db_estado=0 and vazio=1 immediately, without waiting for a clock.
   -> After release, the line stays idle until a new write.
6. PARITY=0, DATA_BITS=5, STOP_BITS=1, CLK_DIV=2. Write 5'h15.
   -> Line: 0,1,0,1,0,1,1; 14 cycles; the PARIDADE state is never entered (db_estado never 3).
